// File: rtl/serial_sample_frontend.sv
// serial_sample_frontend: deserializes an asynchronous SPI-style sample stream into
// signed words and presents them to the wavelet core with a stretched strobe.
//   clk            system clock
//   rst            asynchronous reset, active low
//   i_sclk         external serial clock (async), data sampled on its rising edge
//   i_sdata        external serial data (async), MSB first
//   i_cs_n         external frame select (async), active low
//   i_clear_flags  synchronous pulse clearing o_frame_err and o_overrun
//   o_value        last accepted sample
//   o_data_clk     sample strobe, high STROBE_CYCLES clk per accepted word
//   o_frame_err    sticky: frame ended with a partial word
//   o_overrun      sticky: word completed while the strobe was still high
//   o_word_count   accepted words, wraps modulo 256
module serial_sample_frontend #(
    parameter int BITS_PER_ELEM = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STROBE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_sclk,
    input  logic                     i_sdata,
    input  logic                     i_cs_n,
    input  logic                     i_clear_flags,
    output logic [BITS_PER_ELEM-1:0] o_value,
    output logic                     o_data_clk,
    output logic                     o_frame_err,
    output logic                     o_overrun,
    output logic [7:0]               o_word_count
);
    localparam int CW = $clog2(BITS_PER_ELEM) + 1;
    localparam int SW = $clog2(STROBE_CYCLES + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sclk_sync_q, sdata_sync_q, cs_sync_q;
    logic                     sclk_prev_q;
    logic [BITS_PER_ELEM-1:0] shift_q, shift_d, value_q, value_d, word;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SW-1:0]            strobe_q, strobe_d;
    logic                     dclk_q, dclk_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic [7:0]               wc_q, wc_d;
    logic                     sclk_s, sdata_s, cs_n_s, sclk_rise;
    logic                     word_done, frame_ev, accept;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign word      = {shift_q[BITS_PER_ELEM-2:0], sdata_s};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        frame_ev  = 1'b0;
        if (state_q == IDLE) begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = cs_n_s ? IDLE : SHIFT;
        end else if (cs_n_s) begin
            // frame end takes priority over a coincident sclk edge
            state_d  = IDLE;
            frame_ev = cnt_q != '0;
            cnt_d    = '0;
        end else if (sclk_rise) begin
            shift_d   = word;
            word_done = cnt_q == CW'(BITS_PER_ELEM - 1);
            cnt_d     = word_done ? '0 : cnt_q + 1'b1;
        end
    end

    // a word is only taken while the strobe is low; otherwise it is an overrun
    assign accept   = word_done & ~dclk_q;
    assign value_d  = accept ? word : value_q;
    assign dclk_d   = accept | (dclk_q & (strobe_q != '0));
    assign strobe_d = accept ? SW'(STROBE_CYCLES - 1) : (strobe_q != '0 ? strobe_q - 1'b1 : strobe_q);
    assign wc_d     = wc_q + 8'(accept);
    assign ferr_d   = frame_ev | (ferr_q & ~i_clear_flags);
    assign ovr_d    = (word_done & dclk_q) | (ovr_q & ~i_clear_flags);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            cs_sync_q    <= '1;
            sclk_prev_q  <= 1'b0;
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            value_q      <= '0;
            strobe_q     <= '0;
            dclk_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
            wc_q         <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i_sdata};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
            sclk_prev_q  <= sclk_s;
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            value_q      <= value_d;
            strobe_q     <= strobe_d;
            dclk_q       <= dclk_d;
            ferr_q       <= ferr_d;
            ovr_q        <= ovr_d;
            wc_q         <= wc_d;
        end
    end

    assign o_value      = value_q;
    assign o_data_clk   = dclk_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;
    assign o_word_count = wc_q;
endmodule

// File: tb/tb_serial_sample_frontend.sv
// tb_serial_sample_frontend: scoreboard bench for serial_sample_frontend.
module tb_serial_sample_frontend;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0, sdata = 1'b0, cs_n = 1'b1, clr = 1'b0;
    logic [7:0] val, val_o, wc, wc_o;
    logic       dclk, dclk_o, ferr, ferr_o, ovr, ovr_o;
    int         checks = 0, failures = 0, strobes = 0;
    logic [7:0] sb[$];
    logic       dclk_prev = 1'b0;

    always #5 clk = ~clk;

    serial_sample_frontend u_dut (
        .clk(clk), .rst(rst), .i_sclk(sclk), .i_sdata(sdata), .i_cs_n(cs_n),
        .i_clear_flags(clr), .o_value(val), .o_data_clk(dclk), .o_frame_err(ferr),
        .o_overrun(ovr), .o_word_count(wc)
    );

    serial_sample_frontend #(.STROBE_CYCLES(40)) u_ovr (
        .clk(clk), .rst(rst), .i_sclk(sclk), .i_sdata(sdata), .i_cs_n(cs_n),
        .i_clear_flags(clr), .o_value(val_o), .o_data_clk(dclk_o), .o_frame_err(ferr_o),
        .o_overrun(ovr_o), .o_word_count(wc_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every strobe rising edge of the default instance must present the next queued word
    always @(negedge clk) begin
        if (rst && dclk && !dclk_prev) begin
            strobes++;
            if (sb.size() == 0) check("unexpected_strobe", 32'(val), 32'hxx);
            else check("sb_value", 32'(val), 32'(sb.pop_front()));
        end
        dclk_prev = rst ? dclk : 1'b0;
    end

    task automatic do_reset();
        rst = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end(input int half);
        sclk = 1'b0;
        repeat (half) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // shifts the top n bits of w; with lat set, the last high phase checks strobe timing
    task automatic send_bits(input logic [7:0] w, input int n, input int half, input bit lat);
        for (int i = 7; i > 7 - n; i--) begin
            sdata = w[i];
            sclk = 1'b0;
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            if (i == 0) sb.push_back(w);
            if (i == 0 && lat) begin
                repeat (2) @(negedge clk);
                check("lat_early", 32'(dclk), 0);
                @(negedge clk);
                check("lat_strobe", 32'(dclk), 1);
                check("lat_value", 32'(val), 32'(w));
            end else begin
                repeat (half) @(negedge clk);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, 32'(val), 0);
        check({tag, "_dclk"}, 32'(dclk), 0);
        check({tag, "_ferr"}, 32'(ferr), 0);
        check({tag, "_ovr"}, 32'(ovr), 0);
        check({tag, "_count"}, 32'(wc), 0);
    endtask

    initial begin
        int hi, s0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_ovr_inst_dclk", 32'(dclk_o), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single 0xA5 word, latency and strobe width
        frame_start();
        send_bits(8'hA5, 8, 4, 1'b1);
        hi = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!dclk) break;
            hi++;
        end
        check("strobe_width", 32'(hi), 4);
        frame_end(4);
        check("t1_count", 32'(wc), 1);
        check("t1_ferr", 32'(ferr), 0);
        check("t1_ovr", 32'(ovr), 0);

        // three words in one frame
        do_reset();
        s0 = strobes;
        frame_start();
        send_bits(8'h80, 8, 8, 1'b0);
        send_bits(8'h7F, 8, 8, 1'b0);
        send_bits(8'hFF, 8, 8, 1'b0);
        frame_end(8);
        check("t2_strobes", 32'(strobes - s0), 3);
        check("t2_count", 32'(wc), 3);
        check("t2_value", 32'(val), 32'hFF);

        // partial word then a clean frame
        do_reset();
        frame_start();
        send_bits(8'h3C, 5, 4, 1'b0);
        frame_end(4);
        check("t3_ferr_set", 32'(ferr), 1);
        check("t3_count0", 32'(wc), 0);
        frame_start();
        send_bits(8'h11, 8, 4, 1'b0);
        frame_end(4);
        check("t3_value", 32'(val), 32'h11);
        check("t3_count", 32'(wc), 1);
        check("t3_ferr_hold", 32'(ferr), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_ferr_clr", 32'(ferr), 0);

        // long strobe instance overruns on the second word
        do_reset();
        frame_start();
        send_bits(8'h12, 8, 2, 1'b0);
        send_bits(8'h34, 8, 2, 1'b0);
        frame_end(2);
        repeat (45) @(negedge clk);
        check("t4_ovr", 32'(ovr_o), 1);
        check("t4_value", 32'(val_o), 32'h12);
        check("t4_count", 32'(wc_o), 1);
        check("t4_dclk_low", 32'(dclk_o), 0);
        check("t4_dflt_count", 32'(wc), 2);
        check("t4_dflt_ovr", 32'(ovr), 0);

        // 256 words wrap the counter
        do_reset();
        frame_start();
        for (int k = 0; k < 256; k++) send_bits(8'h01, 8, 4, 1'b0);
        frame_end(4);
        check("t5_count_wrap", 32'(wc), 0);
        check("t5_value", 32'(val), 32'h01);

        // asynchronous reset mid-word and mid-strobe
        do_reset();
        frame_start();
        send_bits(8'hC3, 8, 4, 1'b0);
        send_bits(8'hFF, 4, 4, 1'b0);
        check("t6_pre_count", 32'(wc), 1);
        #2 rst = 1'b0;
        #1 check_zero("t6_midword");
        sclk = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        frame_start();
        send_bits(8'h5A, 8, 4, 1'b1);
        #2 rst = 1'b0;
        #1 check_zero("t6_midstrobe");
        sclk = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        frame_start();
        send_bits(8'h5A, 8, 4, 1'b0);
        frame_end(4);
        check("t6_value", 32'(val), 32'h5A);
        check("t6_count", 32'(wc), 1);
        check("t6_ferr", 32'(ferr), 0);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
